// File: rtl/evt_enc_pkg.sv
// ----------------------------------------------------------------------------
// evt_enc_pkg
// Shared sizes, types and helpers for the 8-to-3 event encoder.
//   N_EVT       number of event lines
//   CODE_W      width of a binary event index
//   evt_vec_t   one bit per event line
//   evt_code_t  binary event index
//   onehot_idx  binary index of the set bit in a one-hot vector
// ----------------------------------------------------------------------------
package evt_enc_pkg;

    localparam int N_EVT  = 8;
    localparam int CODE_W = $clog2(N_EVT);

    typedef logic [N_EVT-1:0]  evt_vec_t;
    typedef logic [CODE_W-1:0] evt_code_t;

    // For a one-hot input the OR of the indices of all set bits is exactly the
    // index of the single set bit. The result is 0 for an all-zero input.
    function automatic evt_code_t onehot_idx(input evt_vec_t v);
        evt_code_t idx;
        idx = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (v[i]) begin
                idx = idx | CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
// Combinational picker. Returns the first set bit of cand, scanning from
// ptr upwards and wrapping (round-robin), or from bit 0 when rr_en is low
// (fixed priority, lowest index wins).
//   cand   in   candidate event bitmap
//   ptr    in   round-robin start index
//   rr_en  in   1 = round-robin, 0 = fixed priority
//   sel    out  selected index (only meaningful when any = 1)
//   any    out  cand has at least one bit set
// ----------------------------------------------------------------------------
module rr_priority_pick
    import evt_enc_pkg::*;
(
    input  evt_vec_t  cand,
    input  evt_code_t ptr,
    input  logic      rr_en,
    output evt_code_t sel,
    output logic      any
);

    evt_code_t          w_ptr;
    logic [2*N_EVT-1:0] w_dbl;
    evt_vec_t           w_rot;
    evt_vec_t           w_low;

    // Fixed priority is simply round-robin with the start pinned at 0.
    assign w_ptr = rr_en ? ptr : '0;

    // Rotate right by w_ptr so the start position lands on bit 0.
    assign w_dbl = {cand, cand} >> w_ptr;
    assign w_rot = w_dbl[N_EVT-1:0];

    // Isolate the lowest set bit (two's-complement trick).
    assign w_low = w_rot & (~w_rot + evt_vec_t'(1));

    // Undo the rotation; the CODE_W-bit add wraps modulo N_EVT.
    assign sel = onehot_idx(w_low) + w_ptr;
    assign any = |cand;

endmodule

// File: rtl/event_encoder_8to3.sv
// ----------------------------------------------------------------------------
// event_encoder_8to3
// Collects single-cycle event pulses on 8 lines into a pending bitmap and
// issues them one at a time as 3-bit indices on a valid/ready stream.
//   RR_EN      param  1 = round-robin issue order, 0 = lowest index first
//   clk        in     clock, rising edge
//   rst_n      in     synchronous active-low reset
//   evt_in     in     event pulses, any number per cycle
//   out_valid  out    out_code holds an issued event index
//   out_code   out    issued event index
//   out_ready  in     consumer accepts when out_valid && out_ready
//   pending    out    events queued but not yet in the output slot
//   overflow   out    sticky: an event merged into one already queued/held
//   ovf_clr    in     clears overflow (a new set in the same cycle wins)
// ----------------------------------------------------------------------------
module event_encoder_8to3
    import evt_enc_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  evt_vec_t  evt_in,
    output logic      out_valid,
    output evt_code_t out_code,
    input  logic      out_ready,
    output evt_vec_t  pending,
    output logic      overflow,
    input  logic      ovf_clr
);

    logic      r_out_valid;
    evt_code_t r_out_code;
    evt_vec_t  r_pending;
    evt_code_t r_rr_ptr;
    logic      r_overflow;

    evt_vec_t  w_cand;
    logic      w_slot_free;
    evt_code_t w_sel;
    logic      w_any;
    evt_vec_t  w_sel_mask;
    evt_vec_t  w_held_mask;
    logic      w_ovf_set;

    assign w_cand      = r_pending | evt_in;
    assign w_slot_free = !r_out_valid || out_ready;

    rr_priority_pick u_pick (
        .cand  (w_cand),
        .ptr   (r_rr_ptr),
        .rr_en (RR_EN),
        .sel   (w_sel),
        .any   (w_any)
    );

    // w_sel_mask: one-hot of the index being loaded into the slot.
    // w_held_mask: one-hot of the code sitting in a stalled slot; an event on
    // that line merges with it. When the slot is being accepted the same
    // event is a fresh one and is allowed to re-queue.
    genvar gi;
    generate
        for (gi = 0; gi < N_EVT; gi++) begin : g_masks
            assign w_sel_mask[gi]  = (w_sel == CODE_W'(gi));
            assign w_held_mask[gi] = r_out_valid && !out_ready &&
                                     (r_out_code == CODE_W'(gi));
        end
    endgenerate

    assign w_ovf_set = |(evt_in & (r_pending | w_held_mask));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_slot_free) begin
                if (w_any) begin
                    r_out_valid <= 1'b1;
                    r_out_code  <= w_sel;
                    r_pending   <= w_cand & ~w_sel_mask;
                    if (RR_EN) begin
                        r_rr_ptr <= w_sel + evt_code_t'(1);
                    end
                end else begin
                    // Nothing to issue: code holds, pending is already empty.
                    r_out_valid <= 1'b0;
                    r_pending   <= w_cand;
                end
            end else begin
                // Stalled: slot stays stable, new events keep queuing.
                r_pending <= w_cand;
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// ----------------------------------------------------------------------------
// tb_event_encoder_8to3
// Two encoders side by side: u_fix (fixed priority) and u_rr (round-robin).
// Each table row drives one cycle of inputs and lists the outputs expected
// just after the following rising edge.
// ----------------------------------------------------------------------------
module tb_event_encoder_8to3;

    typedef struct {
        logic       rst_n;
        logic [7:0] evt;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [2:0] code;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst0_n, rdy0, clr0;
    logic [7:0] evt0;
    logic       v0, o0;
    logic [2:0] c0;
    logic [7:0] p0;
    logic       rst1_n, rdy1, clr1;
    logic [7:0] evt1;
    logic       v1, o1;
    logic [2:0] c1;
    logic [7:0] p1;

    int checks = 0;
    int errors = 0;

    vec_t tab0[26];
    vec_t tab1[24];

    always #5 clk = ~clk;

    event_encoder_8to3 #(.RR_EN(1'b0)) u_fix (
        .clk(clk), .rst_n(rst0_n), .evt_in(evt0), .out_valid(v0), .out_code(c0),
        .out_ready(rdy0), .pending(p0), .overflow(o0), .ovf_clr(clr0)
    );

    event_encoder_8to3 #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst1_n), .evt_in(evt1), .out_valid(v1), .out_code(c1),
        .out_ready(rdy1), .pending(p1), .overflow(o1), .ovf_clr(clr1)
    );

    function automatic vec_t mk(input logic r, input logic [7:0] e, input logic rd,
                                input logic cl, input logic ev, input logic [2:0] ec,
                                input logic [7:0] ep, input logic eo);
        vec_t t;
        t.rst_n = r; t.evt = e; t.rdy = rd; t.clr = cl;
        t.v = ev; t.code = ec; t.pend = ep; t.ovf = eo;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one row on the selected DUT, clock it, then compare.
    task automatic run_row(input int d, input int idx, input vec_t t);
        logic       av, ao;
        logic [2:0] ac;
        logic [7:0] ap;
        string      tag;
        if (d == 0) begin
            rst0_n = t.rst_n; evt0 = t.evt; rdy0 = t.rdy; clr0 = t.clr;
        end else begin
            rst1_n = t.rst_n; evt1 = t.evt; rdy1 = t.rdy; clr1 = t.clr;
        end
        @(posedge clk);
        #1;
        if (d == 0) begin
            av = v0; ac = c0; ap = p0; ao = o0;
            evt0 = 8'h00; clr0 = 1'b0;
        end else begin
            av = v1; ac = c1; ap = p1; ao = o1;
            evt1 = 8'h00; clr1 = 1'b0;
        end
        tag = $sformatf("%s[%0d]", (d == 0) ? "fix" : "rr", idx);
        $display("%s rst_n=%0b evt=%02h rdy=%0b clr=%0b -> valid=%0b code=%0d pending=%02h ovf=%0b",
                 tag, t.rst_n, t.evt, t.rdy, t.clr, av, ac, ap, ao);
        chk({tag, ".valid"}, int'(av), int'(t.v));
        if (t.v || d == 0 || !t.rst_n) begin
            chk({tag, ".code"}, int'(ac), int'(t.code));
        end
        chk({tag, ".pending"}, int'(ap), int'(t.pend));
        chk({tag, ".overflow"}, int'(ao), int'(t.ovf));
    endtask

    initial begin
        // Fixed priority: single, burst, stall, overflow.
        tab0[0]  = mk(1, 8'h20, 1, 0, 1, 3'd5, 8'h00, 0);
        tab0[1]  = mk(1, 8'h00, 1, 0, 0, 3'd5, 8'h00, 0);
        tab0[2]  = mk(1, 8'h85, 1, 0, 1, 3'd0, 8'h84, 0);
        tab0[3]  = mk(1, 8'h00, 1, 0, 1, 3'd2, 8'h80, 0);
        tab0[4]  = mk(1, 8'h00, 1, 0, 1, 3'd7, 8'h00, 0);
        tab0[5]  = mk(1, 8'h00, 1, 0, 0, 3'd7, 8'h00, 0);
        tab0[6]  = mk(1, 8'h08, 0, 0, 1, 3'd3, 8'h00, 0);
        tab0[7]  = mk(1, 8'h03, 0, 0, 1, 3'd3, 8'h03, 0);
        tab0[8]  = mk(1, 8'h00, 0, 0, 1, 3'd3, 8'h03, 0);
        tab0[9]  = mk(1, 8'h00, 0, 0, 1, 3'd3, 8'h03, 0);
        tab0[10] = mk(1, 8'h00, 0, 0, 1, 3'd3, 8'h03, 0);
        tab0[11] = mk(1, 8'h00, 1, 0, 1, 3'd0, 8'h02, 0);
        tab0[12] = mk(1, 8'h00, 1, 0, 1, 3'd1, 8'h00, 0);
        tab0[13] = mk(1, 8'h00, 1, 0, 0, 3'd1, 8'h00, 0);
        tab0[14] = mk(1, 8'h04, 0, 0, 1, 3'd2, 8'h00, 0);
        tab0[15] = mk(1, 8'h10, 0, 0, 1, 3'd2, 8'h10, 0);
        tab0[16] = mk(1, 8'h10, 0, 0, 1, 3'd2, 8'h10, 1);
        tab0[17] = mk(1, 8'h00, 1, 0, 1, 3'd4, 8'h00, 1);
        tab0[18] = mk(1, 8'h00, 0, 1, 1, 3'd4, 8'h00, 0);
        tab0[19] = mk(1, 8'h10, 1, 0, 1, 3'd4, 8'h00, 0);
        tab0[20] = mk(1, 8'h00, 1, 0, 0, 3'd4, 8'h00, 0);
        tab0[21] = mk(1, 8'h40, 0, 0, 1, 3'd6, 8'h00, 0);
        tab0[22] = mk(1, 8'h40, 0, 0, 1, 3'd6, 8'h40, 1);
        tab0[23] = mk(1, 8'h40, 0, 1, 1, 3'd6, 8'h40, 1);
        tab0[24] = mk(1, 8'h00, 1, 0, 1, 3'd6, 8'h00, 1);
        tab0[25] = mk(1, 8'h00, 1, 1, 0, 3'd6, 8'h00, 0);

        // Round-robin: 8'hFF held 10 cycles gives 0..7,0,1; the line just
        // issued is the only one missing from pending.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] one;
            one = 8'h01 << (i % 8);
            tab1[i] = mk(1, 8'hFF, 1, 0, 1, 3'(i % 8), ~one, (i > 0) ? 1'b1 : 1'b0);
        end
        tab1[10] = mk(0, 8'hFF, 1, 0, 0, 3'd0, 8'h00, 0);
        tab1[11] = mk(1, 8'h82, 1, 0, 1, 3'd1, 8'h80, 0);
        tab1[12] = mk(1, 8'h00, 1, 0, 1, 3'd7, 8'h00, 0);
        tab1[13] = mk(1, 8'h00, 1, 0, 0, 3'd7, 8'h00, 0);
        tab1[14] = mk(1, 8'hF8, 0, 0, 1, 3'd3, 8'hF0, 0);
        tab1[15] = mk(0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 0);
        tab1[16] = mk(1, 8'h08, 0, 0, 1, 3'd3, 8'h00, 0);
        tab1[17] = mk(1, 8'h03, 0, 0, 1, 3'd3, 8'h03, 0);
        tab1[18] = mk(1, 8'h00, 0, 0, 1, 3'd3, 8'h03, 0);
        tab1[19] = mk(1, 8'h00, 0, 0, 1, 3'd3, 8'h03, 0);
        tab1[20] = mk(1, 8'h00, 0, 0, 1, 3'd3, 8'h03, 0);
        tab1[21] = mk(1, 8'h00, 1, 0, 1, 3'd0, 8'h02, 0);
        tab1[22] = mk(1, 8'h00, 1, 0, 1, 3'd1, 8'h00, 0);
        tab1[23] = mk(1, 8'h00, 1, 0, 0, 3'd1, 8'h00, 0);

        // Reset held two cycles with all event lines active.
        rst0_n = 1'b0; evt0 = 8'hFF; rdy0 = 1'b1; clr0 = 1'b0;
        rst1_n = 1'b0; evt1 = 8'hFF; rdy1 = 1'b1; clr1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: fix valid=%0b pending=%02h ovf=%0b | rr valid=%0b pending=%02h ovf=%0b",
                 v0, p0, o0, v1, p1, o1);
        chk("reset.fix.valid", int'(v0), 0);
        chk("reset.fix.code", int'(c0), 0);
        chk("reset.fix.pending", int'(p0), 0);
        chk("reset.fix.overflow", int'(o0), 0);
        chk("reset.rr.valid", int'(v1), 0);
        chk("reset.rr.pending", int'(p1), 0);
        chk("reset.rr.overflow", int'(o1), 0);
        evt0 = 8'h00;
        evt1 = 8'h00;

        foreach (tab0[i]) run_row(0, i, tab0[i]);
        foreach (tab1[i]) run_row(1, i, tab1[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
